ps2lab_axil_slave: RTL

//  AXI4-Lite responder for the ps2lab subsystem; the completer for the ps2lab AXI-Lite master.

---
 rtl/ps2lab_axil_slave.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ps2lab_axil_slave.sv
// AXI4-Lite completer for the ps2lab block: CTRL/STATUS/DATA/SCRATCH registers
// in front of a scancode FIFO filled by the PS/2 receive path.
module ps2lab_axil_slave #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned FIFO_DEPTH         = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    input  logic [7:0]                      scan_code,
    input  logic                            scan_valid,
    output logic                            irq
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    localparam logic [1:0] RegCtrl    = 2'd0;
    localparam logic [1:0] RegStatus  = 2'd1;
    localparam logic [1:0] RegData    = 2'd2;

    typedef enum logic {WIdle, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    // Write channel state
    w_state_e    w_state_q, w_state_d;
    logic        aw_held_q, aw_held_d;
    logic        w_held_q, w_held_d;
    logic        aw_ready_q, aw_ready_d;
    logic        w_ready_q, w_ready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        wr_commit;
    logic [1:0]  wr_resp;

    // Read channel state
    r_state_e    r_state_q, r_state_d;
    logic        ar_ready_q, ar_ready_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] rd_mux;
    logic        rd_hs;

    // Registers and FIFO
    logic            ctrl_en_q, ctrl_irq_en_q;
    logic [31:0]     scratch_q;
    logic            ovf_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [7:0]      count_byte;
    logic            fifo_empty, fifo_full;
    logic            push, pop, flush, ovf_set, ovf_clr;

    // Address bits [1:0] select bytes within a word and play no part in decode
    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign count_byte = 8'(count_q);

    // STATUS writes are only accepted when they clear the overflow flag
    always_comb begin
        wr_resp = RespOkay;
        unique case (waddr_q)
            RegStatus: wr_resp = (wstrb_q[0] && wdata_q[2]) ? RespOkay : RespSlverr;
            RegData:   wr_resp = RespSlverr;
            default:   wr_resp = RespOkay;
        endcase
    end

    // Write FSM: capture AW and W independently, commit once both are held
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wr_commit = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                if (aw_held_q && w_held_q) begin
                    wr_commit = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_resp;
                    w_state_d = WResp;
                end else begin
                    if (S_AXI_AWVALID && aw_ready_q) begin
                        aw_held_d = 1'b1;
                        waddr_d   = S_AXI_AWADDR[3:2];
                    end
                    if (S_AXI_WVALID && w_ready_q) begin
                        w_held_d = 1'b1;
                        wdata_d  = S_AXI_WDATA[31:0];
                        wstrb_d  = S_AXI_WSTRB[3:0];
                    end
                end
            end
            WResp: begin
                if (S_AXI_BREADY) begin
                    bvalid_d  = 1'b0;
                    w_state_d = WIdle;
                end
            end
        endcase
        aw_ready_d = (w_state_d == WIdle) && !aw_held_d;
        w_ready_d  = (w_state_d == WIdle) && !w_held_d;
    end

    // Write channel state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q  <= WIdle;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RespOkay;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

    assign flush   = wr_commit && (waddr_q == RegCtrl) && wstrb_q[0] && wdata_q[1];
    assign ovf_clr = wr_commit && (waddr_q == RegStatus) && wstrb_q[0] && wdata_q[2];

    // CTRL and SCRATCH updates; flush is a pulse and is not stored
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_en_q     <= 1'b0;
            ctrl_irq_en_q <= 1'b0;
            scratch_q     <= '0;
        end else if (wr_commit) begin
            if (waddr_q == RegCtrl && wstrb_q[0]) begin
                ctrl_en_q     <= wdata_q[0];
                ctrl_irq_en_q <= wdata_q[2];
            end
            if (waddr_q == 2'd3) begin
                for (int i = 0; i < 4; i++) begin
                    if (wstrb_q[i]) scratch_q[8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Register read mux
    always_comb begin
        rd_mux = '0;
        unique case (S_AXI_ARADDR[3:2])
            RegCtrl:   rd_mux = {29'b0, ctrl_irq_en_q, 1'b0, ctrl_en_q};
            RegStatus: rd_mux = {16'b0, count_byte, 5'b0, ovf_q, fifo_full, fifo_empty};
            RegData:   rd_mux = fifo_empty ? 32'b0 : {23'b0, 1'b1, mem_q[rd_ptr_q]};
            default:   rd_mux = scratch_q;
        endcase
    end

    assign rd_hs = S_AXI_ARVALID && ar_ready_q;

    // Read FSM: latch data on the AR handshake, hold until RREADY
    always_comb begin
        r_state_d = r_state_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        unique case (r_state_q)
            RIdle: begin
                if (rd_hs) begin
                    rdata_d   = rd_mux;
                    rvalid_d  = 1'b1;
                    r_state_d = RData;
                end
            end
            RData: begin
                if (S_AXI_RREADY) begin
                    rvalid_d  = 1'b0;
                    r_state_d = RIdle;
                end
            end
        endcase
        ar_ready_d = (r_state_d == RIdle);
    end

    // Read channel state register
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_q  <= RIdle;
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            r_state_q  <= r_state_d;
            ar_ready_q <= ar_ready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    // A pop frees a slot on the same edge, so a push into a full FIFO is legal then
    assign pop     = rd_hs && (S_AXI_ARADDR[3:2] == RegData) && !fifo_empty && !flush;
    assign push    = scan_valid && ctrl_en_q && (!fifo_full || pop) && !flush;
    assign ovf_set = scan_valid && ctrl_en_q && fifo_full && !pop && !flush;

    // FIFO pointers and count; flush wins over push/pop
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Sticky overflow; a new drop outranks a same-cycle clear
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)     ovf_q <= 1'b0;
        else if (ovf_set) ovf_q <= 1'b1;
        else if (ovf_clr) ovf_q <= 1'b0;
    end

    // FIFO storage, contents are don't-care until pushed
    always_ff @(posedge ACLK) begin
        if (push) mem_q[wr_ptr_q] <= scan_code;
    end

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = w_ready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign irq           = ctrl_en_q && ctrl_irq_en_q && !fifo_empty;

endmodule
